// File: rtl/quick_mem_port.sv
// Memory responder for quick-CPU cores: request/response port with a fixed
// number of wait states, an out-of-range error flag and a side-band preload port.
module quick_mem_port #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              busy
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                busy_q, busy_d;

   logic                accept;
   logic                commit;
   logic [ADDR_W-1:0]   c_addr;
   logic                c_write;
   logic [DATA_W-1:0]   c_wdata;
   logic                c_in_range;
   logic                ld_in_range;

   logic [DATA_W-1:0]   mem [DEPTH];

   assign req_ready   = ((state_q == IDLE) || (state_q == RESP)) && !ld_en;
   assign accept      = req_valid && req_ready;
   assign ld_in_range = 32'(ld_addr) < DEPTH;

   // Next state; commit marks the edge entering RESP, where memory is touched.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      commit      = 1'b0;
      c_addr      = addr_q;
      c_write     = write_q;
      c_wdata     = wdata_q;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      unique case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               addr_d  = req_addr;
               write_d = req_write;
               wdata_d = req_wdata;
               if (LATENCY == 1) begin
                  state_d = RESP;
                  commit  = 1'b1;
                  c_addr  = req_addr;
                  c_write = req_write;
                  c_wdata = req_wdata;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               commit  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      c_in_range = 32'(c_addr) < DEPTH;
      if (commit) begin
         if (!c_in_range) begin
            rsp_err_d = 1'b1;
         end else if (!c_write) begin
            rsp_rdata_d = mem[IDX_W'(c_addr)];
         end
      end
      rsp_valid_d = commit;
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   // Array keeps its contents through reset; the request write is last so it wins.
   always_ff @(posedge clk) begin
      if (ld_en && ld_in_range) begin
         mem[IDX_W'(ld_addr)] <= ld_data;
      end
      if (rst_n && commit && c_write && c_in_range) begin
         mem[IDX_W'(c_addr)] <= c_wdata;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_quick_mem_port.sv
// Bench for quick_mem_port: two instances (latency 1 / depth 128 and latency 3 /
// depth 256) checked against a transaction-level model of memory and timing.
module tb_quick_mem_port;

   localparam int unsigned AW   = 8;
   localparam int unsigned DW   = 8;
   localparam int unsigned LAT0 = 1;
   localparam int unsigned LAT1 = 3;
   localparam int unsigned DEP0 = 128;
   localparam int unsigned DEP1 = 256;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid [2];
   logic       req_ready [2];
   logic       req_write [2];
   logic [7:0] req_addr  [2];
   logic [7:0] req_wdata [2];
   logic       rsp_valid [2];
   logic [7:0] rsp_rdata [2];
   logic       rsp_err   [2];
   logic       ld_en     [2];
   logic [7:0] ld_addr   [2];
   logic [7:0] ld_data   [2];
   logic       busy      [2];

   always #5 clk = ~clk;

   quick_mem_port #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP0), .LATENCY(LAT0)) u_d0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
      .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .busy(busy[0])
   );

   quick_mem_port #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP1), .LATENCY(LAT1)) u_d1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
      .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .busy(busy[1])
   );

   int errors = 0;
   int checks = 0;
   int lat [2];
   int dep [2];
   int edge_n = 0;

   // Reference model: memory image plus the single outstanding request.
   logic [7:0] mm [2][256];
   bit         p_valid  [2];
   int         p_commit [2];
   logic [7:0] p_addr   [2];
   logic [7:0] p_wdata  [2];
   bit         p_write  [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge: predict ready/accept, advance the model, check outputs.
   task automatic step();
      bit         acc     [2];
      bit         rdy;
      bit         e_valid [2];
      logic [7:0] e_rdata [2];
      bit         e_err   [2];
      #1;
      for (int d = 0; d < 2; d++) begin
         rdy = !ld_en[d] && !(p_valid[d] && p_commit[d] >= edge_n + 1);
         chk($sformatf("req_ready[%0d]@%0d", d, edge_n), 32'(req_ready[d]), 32'(rdy));
         acc[d] = req_valid[d] && rdy;
      end
      @(posedge clk);
      edge_n++;
      for (int d = 0; d < 2; d++) begin
         if (acc[d]) begin
            p_valid[d]  = 1'b1;
            p_commit[d] = edge_n + lat[d] - 1;
            p_addr[d]   = req_addr[d];
            p_write[d]  = req_write[d];
            p_wdata[d]  = req_wdata[d];
         end
         e_valid[d] = 1'b0;
         e_rdata[d] = 8'h00;
         e_err[d]   = 1'b0;
         if (p_valid[d] && p_commit[d] == edge_n) begin
            e_valid[d] = 1'b1;
            if (int'(p_addr[d]) >= dep[d]) e_err[d] = 1'b1;
            else if (!p_write[d]) e_rdata[d] = mm[d][p_addr[d]];
         end
         if (ld_en[d] && int'(ld_addr[d]) < dep[d]) mm[d][ld_addr[d]] = ld_data[d];
         if (e_valid[d] && p_write[d] && int'(p_addr[d]) < dep[d]) mm[d][p_addr[d]] = p_wdata[d];
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rsp_valid[%0d]@%0d", d, edge_n), 32'(rsp_valid[d]), 32'(e_valid[d]));
         chk($sformatf("rsp_rdata[%0d]@%0d", d, edge_n), 32'(rsp_rdata[d]), 32'(e_rdata[d]));
         if (e_valid[d])
            chk($sformatf("rsp_err[%0d]@%0d", d, edge_n), 32'(rsp_err[d]), 32'(e_err[d]));
         chk($sformatf("busy[%0d]@%0d", d, edge_n), 32'(busy[d]),
             32'(p_valid[d] && p_commit[d] >= edge_n));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s req_ready[%0d]", tag, d), 32'(req_ready[d]), 32'(1));
         chk($sformatf("%s rsp_valid[%0d]", tag, d), 32'(rsp_valid[d]), 32'(0));
         chk($sformatf("%s rsp_rdata[%0d]", tag, d), 32'(rsp_rdata[d]), 32'(0));
         chk($sformatf("%s rsp_err[%0d]", tag, d), 32'(rsp_err[d]), 32'(0));
         chk($sformatf("%s busy[%0d]", tag, d), 32'(busy[d]), 32'(0));
      end
   endtask

   task automatic do_reset(input int n);
      #1;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) p_valid[d] = 1'b0;
      #1;
      chk_reset_vals("rst_assert");
      repeat (n) begin
         @(posedge clk);
         edge_n++;
         #1;
         chk_reset_vals("rst_hold");
      end
      rst_n = 1'b1;
      #1;
      chk_reset_vals("rst_release");
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         ld_en[d]     = 1'b0;
      end
   endtask

   task automatic set_req(input int d, input bit w, input logic [7:0] a, input logic [7:0] wd);
      req_valid[d] = 1'b1;
      req_write[d] = w;
      req_addr[d]  = a;
      req_wdata[d] = wd;
   endtask

   task automatic set_ld(input int d, input logic [7:0] a, input logic [7:0] dat);
      ld_en[d]   = 1'b1;
      ld_addr[d] = a;
      ld_data[d] = dat;
   endtask

   initial begin
      lat = '{int'(LAT0), int'(LAT1)};
      dep = '{int'(DEP0), int'(DEP1)};
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 8'h00; req_wdata[d] = 8'h00;
         ld_en[d] = 1'b0; ld_addr[d] = 8'h00; ld_data[d] = 8'h00; p_valid[d] = 1'b0;
         p_commit[d] = 0;
      end
      do_reset(3);

      // Fill every address; on the depth-128 instance the upper half (incl. 0xFF) is ignored.
      for (int a = 0; a < 256; a++) begin
         for (int d = 0; d < 2; d++) set_ld(d, 8'(a), 8'($urandom));
         step();
      end
      idle_all();
      step();

      // Preload then back-to-back reads, latency 1.
      set_ld(0, 8'h10, 8'hA5); step();
      set_ld(0, 8'h11, 8'h3C); step();
      ld_en[0] = 1'b0;
      set_req(0, 1'b0, 8'h10, 8'h00); step();
      chk("b2b_first", 32'(rsp_rdata[0]), 32'(8'hA5));
      set_req(0, 1'b0, 8'h11, 8'h00); step();
      chk("b2b_second", 32'(rsp_rdata[0]), 32'(8'h3C));
      req_valid[0] = 1'b0; step();

      // Write then read, latency 3.
      set_req(1, 1'b1, 8'h20, 8'h5A); step();
      req_valid[1] = 1'b0; step(); step();
      chk("wr_rsp_valid", 32'(rsp_valid[1]), 32'(1));
      set_req(1, 1'b0, 8'h20, 8'h00); step();
      req_valid[1] = 1'b0; step(); step();
      chk("wr_readback", 32'(rsp_rdata[1]), 32'(8'h5A));
      step();

      // Out-of-range accesses on the depth-128 instance.
      set_req(0, 1'b0, 8'h80, 8'h00); step();
      chk("oor_err", 32'(rsp_err[0]), 32'(1));
      set_req(0, 1'b1, 8'h80, 8'h90); step();
      set_req(0, 1'b0, 8'h00, 8'h00); step();
      chk("oor_mem0", 32'(rsp_rdata[0]), 32'(mm[0][0]));
      req_valid[0] = 1'b0; step();

      // Preload blocks acceptance until it drops.
      set_ld(0, 8'h40, 8'h66);
      set_req(0, 1'b0, 8'h41, 8'h00); step(); step();
      ld_en[0] = 1'b0; step();
      chk("ld_release_accept", 32'(rsp_valid[0]), 32'(1));
      req_valid[0] = 1'b0; step();

      // Preload and request write hit 0x05 on the same edge.
      set_req(1, 1'b1, 8'h05, 8'h22); step();
      req_valid[1] = 1'b0; step();
      set_ld(1, 8'h05, 8'h11); step();
      ld_en[1] = 1'b0;
      set_req(1, 1'b0, 8'h05, 8'h00); step();
      req_valid[1] = 1'b0; step(); step();
      chk("collide_wins", 32'(rsp_rdata[1]), 32'(8'h22));
      step();

      // Reset while a write is in flight.
      set_ld(1, 8'h30, 8'h01); step();
      ld_en[1] = 1'b0;
      set_req(1, 1'b1, 8'h30, 8'h77); step();
      req_valid[1] = 1'b0; step();
      do_reset(2);
      set_req(1, 1'b0, 8'h30, 8'h00); step();
      req_valid[1] = 1'b0; step(); step();
      chk("abort_readback", 32'(rsp_rdata[1]), 32'(8'h01));
      step();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'($urandom_range(0, 1));
            req_write[d] = 1'($urandom_range(0, 1));
            req_addr[d]  = 8'($urandom);
            req_wdata[d] = 8'($urandom);
            ld_en[d]     = ($urandom_range(0, 4) == 0);
            ld_addr[d]   = 8'($urandom);
            ld_data[d]   = 8'($urandom);
         end
         step();
      end
      idle_all();
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
